pipeline_debug_ctrl: RTL and testbench

- Controller that sequences the five-stage pipeline: loads a program into instruction memory from a byte-command stream, then runs it continuously or in single steps.
- Detects the HALT word at fetch, drains in-flight instructions with bubbles, then parks the pipeline.
- Drives the instruction-memory write port and the global PC enable, pipeline-register enable, bubble and flush controls.

---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/cmd_word_assembler.sv | 62 ++++++
 rtl/pipeline_debug_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_pipeline_debug_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline debug controller: FSM state encoding,
// command byte values and default HALT/drain settings.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_CNT  = 3'd1,
    ST_LOAD_DATA = 3'd2,
    ST_FLUSH     = 3'd3,
    ST_RUN       = 3'd4,
    ST_STEP      = 3'd5,
    ST_DRAIN     = 3'd6,
    ST_HALTED    = 3'd7
  } state_e;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_PAUSE = 8'h50;

  localparam logic [31:0] DEF_HALT_WORD    = 32'hFFFF_FFFF;
  localparam int          DEF_DRAIN_CYCLES = 4;

  // States in which the command port takes a byte.
  function automatic logic accepts_cmd(input state_e s);
    logic r;
    case (s)
      ST_IDLE, ST_LOAD_CNT, ST_LOAD_DATA, ST_RUN, ST_HALTED: r = 1'b1;
      default:                                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmd_word_assembler.sv
// -----------------------------------------------------------------------------
// cmd_word_assembler
// Packs four command bytes little-endian into one instruction word and
// pulses o_word_valid for one cycle (the cycle after the 4th byte).
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_clear       - drop any partial word (byte index back to 0)
//   i_byte_valid  - accepted byte this cycle
//   i_byte        - byte value
//   o_word        - assembled word (valid while o_word_valid=1)
//   o_word_valid  - one-cycle pulse per completed word
// -----------------------------------------------------------------------------
module cmd_word_assembler #(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte,
  output logic [NBITS-1:0] o_word,
  output logic             o_word_valid
);

  logic [NBITS-1:0] word_q, word_d;
  logic [1:0]       idx_q, idx_d;
  logic             valid_q, valid_d;

  // Next-state: bytes enter at the top and shift down, so the first byte
  // of a word ends up in [7:0] after the fourth shift.
  always_comb begin
    word_d  = word_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    if (i_clear) begin
      idx_d = 2'd0;
    end else if (i_byte_valid) begin
      word_d  = {i_byte, word_q[NBITS-1:8]};
      idx_d   = idx_q + 2'd1;
      valid_d = (idx_q == 2'd3);
    end else begin
      idx_d = idx_q;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      word_q  <= '0;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = valid_q;

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_debug_ctrl
// Sequences a five-stage pipeline: loads a program through a byte command
// stream ('L' count bytes...), runs it ('R'), single-steps it ('S') or pauses
// it ('P'). A HALT word at fetch drains ID..WB with bubbles, then parks.
// Optional build macro PIPE_CYCLE_LIMIT_EN adds MAX_CYCLES and o_timeout:
// a RUN reaching o_cycle_count==MAX_CYCLES-1 drains as if HALT were fetched.
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_cmd_valid/i_cmd_data/o_cmd_ready - command byte handshake
//   i_fetched_instr                    - instruction at IF output
//   o_inst_mem_wr_en/addr/data         - instruction-memory write port
//   o_pc_en, o_pipe_en, o_bubble, o_flush - pipeline controls
//   o_halted, o_cycle_count, o_state   - status / debug
// All outputs are registered except o_cmd_ready (decoded from state).
// -----------------------------------------------------------------------------
module pipeline_debug_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int               NBITS        = 32,
  parameter int               IMEM_ADDR_W  = 8,
  parameter logic [NBITS-1:0] HALT_WORD    = DEF_HALT_WORD,
  parameter int               DRAIN_CYCLES = DEF_DRAIN_CYCLES
`ifdef PIPE_CYCLE_LIMIT_EN
  , parameter int             MAX_CYCLES   = 100000
`endif
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cmd_valid,
  input  logic [7:0]             i_cmd_data,
  output logic                   o_cmd_ready,
  input  logic [NBITS-1:0]       i_fetched_instr,
  output logic                   o_inst_mem_wr_en,
  output logic [IMEM_ADDR_W-1:0] o_inst_mem_addr,
  output logic [NBITS-1:0]       o_inst_mem_data,
  output logic                   o_pc_en,
  output logic                   o_pipe_en,
  output logic                   o_bubble,
  output logic                   o_flush,
  output logic                   o_halted,
  output logic [31:0]            o_cycle_count,
  output logic [2:0]             o_state
`ifdef PIPE_CYCLE_LIMIT_EN
  , output logic                 o_timeout
`endif
);

  localparam int DRAIN_W = 8;

  state_e                 state_q, state_d;
  logic [8:0]             words_left_q, words_left_d;
  logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
  logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;
  logic                   pc_en_q, pc_en_d;
  logic                   pipe_en_q, pipe_en_d;
  logic                   bubble_q, bubble_d;
  logic                   flush_q, flush_d;
  logic                   halted_q, halted_d;
  logic [31:0]            count_q, count_d;

  logic                   cmd_ready_s;
  logic                   cmd_hs_s;
  logic                   halt_s;
  logic                   stop_s;
  logic                   enabled_s;
  logic [NBITS-1:0]       asm_word_s;
  logic                   asm_valid_s;

  assign cmd_ready_s = accepts_cmd(state_q);
  assign cmd_hs_s    = i_cmd_valid & cmd_ready_s;
  assign halt_s      = (i_fetched_instr == HALT_WORD);
  // Pipeline advanced during this cycle, so the cycle counter ticks.
  assign enabled_s   = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);

`ifdef PIPE_CYCLE_LIMIT_EN
  logic timeout_q, timeout_d;
  logic limit_s;
  assign limit_s = (count_q == 32'(MAX_CYCLES - 1));
  assign stop_s  = halt_s | limit_s;
`else
  assign stop_s  = halt_s;
`endif

  cmd_word_assembler #(.NBITS(NBITS)) u_asm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (state_q != ST_LOAD_DATA),
    .i_byte_valid (cmd_hs_s && (state_q == ST_LOAD_DATA)),
    .i_byte       (i_cmd_data),
    .o_word       (asm_word_s),
    .o_word_valid (asm_valid_s)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    addr_d       = addr_q;
    drain_cnt_d  = drain_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_hs_s) begin
          case (i_cmd_data)
            CMD_LOAD: state_d = ST_LOAD_CNT;
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            default:  state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_CNT: begin
        if (cmd_hs_s) begin
          // A count byte of zero means a full 256-word load.
          words_left_d = (i_cmd_data == 8'd0) ? 9'd256 : {1'b0, i_cmd_data};
          addr_d       = '0;
          state_d      = ST_LOAD_DATA;
        end else begin
          state_d = ST_LOAD_CNT;
        end
      end
      ST_LOAD_DATA: begin
        // The write cycle is the assembler's valid pulse; advance afterwards.
        if (asm_valid_s) begin
          addr_d       = addr_q + {{(IMEM_ADDR_W-1){1'b0}}, 1'b1};
          words_left_d = words_left_q - 9'd1;
          state_d      = (words_left_q == 9'd1) ? ST_FLUSH : ST_LOAD_DATA;
        end else begin
          state_d = ST_LOAD_DATA;
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      ST_RUN: begin
        // HALT wins over a simultaneous pause; the pause byte is still consumed.
        if (stop_s) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end else if (cmd_hs_s && (i_cmd_data == CMD_PAUSE)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STEP: begin
        if (halt_s) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
          state_d = ST_HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q + {{(DRAIN_W-1){1'b0}}, 1'b1};
        end
      end
      ST_HALTED: begin
        if (cmd_hs_s && (i_cmd_data == CMD_LOAD)) begin
          state_d = ST_LOAD_CNT;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Controls are registered from the next state so they line up with state_q.
    pc_en_d   = (state_d == ST_RUN) || (state_d == ST_STEP);
    pipe_en_d = (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN);
    bubble_d  = (state_d == ST_DRAIN);
    flush_d   = (state_d == ST_FLUSH);

    if (state_d == ST_FLUSH) begin
      halted_d = 1'b0;
    end else if (state_d == ST_HALTED) begin
      halted_d = 1'b1;
    end else begin
      halted_d = halted_q;
    end

    if (state_d == ST_FLUSH) begin
      count_d = 32'd0;
    end else if (enabled_s && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

`ifdef PIPE_CYCLE_LIMIT_EN
  // Sticky timeout flag, cleared only by flush or reset.
  always_comb begin
    if (state_d == ST_FLUSH) begin
      timeout_d = 1'b0;
    end else if ((state_q == ST_RUN) && limit_s && !halt_s) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // Timeout register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`endif

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      words_left_q <= 9'd0;
      addr_q       <= '0;
      drain_cnt_q  <= '0;
      pc_en_q      <= 1'b0;
      pipe_en_q    <= 1'b0;
      bubble_q     <= 1'b0;
      flush_q      <= 1'b0;
      halted_q     <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      addr_q       <= addr_d;
      drain_cnt_q  <= drain_cnt_d;
      pc_en_q      <= pc_en_d;
      pipe_en_q    <= pipe_en_d;
      bubble_q     <= bubble_d;
      flush_q      <= flush_d;
      halted_q     <= halted_d;
      count_q      <= count_d;
    end
  end

  assign o_cmd_ready      = cmd_ready_s;
  assign o_inst_mem_wr_en = asm_valid_s;
  assign o_inst_mem_addr  = addr_q;
  assign o_inst_mem_data  = asm_word_s;
  assign o_pc_en          = pc_en_q;
  assign o_pipe_en        = pipe_en_q;
  assign o_bubble         = bubble_q;
  assign o_flush          = flush_q;
  assign o_halted         = halted_q;
  assign o_cycle_count    = count_q;
  assign o_state          = state_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_debug_ctrl
// Self-checking bench for pipeline_debug_ctrl. Memory writes are checked
// against a scoreboard queue filled as load bytes are driven; control and
// status outputs are checked at falling edges in directed sequences.
// -----------------------------------------------------------------------------
module tb_pipeline_debug_ctrl;

  localparam logic [31:0] NOP_W  = 32'h0000_0013;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_ready;
  logic [31:0] fetched = NOP_W;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pc_en, pipe_en, bubble, flush, halted;
  logic [31:0] cyc;
  logic [2:0]  state;
`ifdef PIPE_CYCLE_LIMIT_EN
  logic        timeout;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] word;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  pipeline_debug_ctrl dut (
    .i_clk            (clk),
    .i_rst            (rst_n),
    .i_cmd_valid      (cmd_valid),
    .i_cmd_data       (cmd_data),
    .o_cmd_ready      (cmd_ready),
    .i_fetched_instr  (fetched),
    .o_inst_mem_wr_en (wr_en),
    .o_inst_mem_addr  (wr_addr),
    .o_inst_mem_data  (wr_data),
    .o_pc_en          (pc_en),
    .o_pipe_en        (pipe_en),
    .o_bubble         (bubble),
    .o_flush          (flush),
    .o_halted         (halted),
    .o_cycle_count    (cyc),
    .o_state          (state)
`ifdef PIPE_CYCLE_LIMIT_EN
    , .o_timeout      (timeout)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin : wr_mon
    wr_t e;
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", {24'd0, wr_addr}, {24'd0, e.addr});
        chk("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=%b, expected 1 within 50 cycles", cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Called right after the last data byte: write cycle, flush cycle, IDLE.
  task automatic expect_flush();
    @(negedge clk);
    @(negedge clk);
    chk("flush_pulse", {31'd0, flush}, 32'd1);
    chk("flush_ready", {31'd0, cmd_ready}, 32'd0);
    chk("flush_state", {29'd0, state}, 32'd3);
    chk("flush_halted", {31'd0, halted}, 32'd0);
    chk("flush_count", cyc, 32'd0);
    @(negedge clk);
    chk("post_flush_pulse", {31'd0, flush}, 32'd0);
    chk("post_flush_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_flush_state", {29'd0, state}, 32'd0);
  endtask

  task automatic load_table(input int first, input int n);
    send_byte(8'h4C);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      sb.push_back({8'(i), tbl[first+i].word});
      send_byte(tbl[first+i].b0);
      send_byte(tbl[first+i].b1);
      send_byte(tbl[first+i].b2);
      send_byte(tbl[first+i].b3);
    end
    expect_flush();
  endtask

  task automatic drain_and_halt(input logic [31:0] exp_count);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_state", {29'd0, state}, 32'd6);
      chk("drain_pc_en", {31'd0, pc_en}, 32'd0);
      chk("drain_pipe_en", {31'd0, pipe_en}, 32'd1);
      chk("drain_bubble", {31'd0, bubble}, 32'd1);
      chk("drain_ready", {31'd0, cmd_ready}, 32'd0);
    end
    @(negedge clk);
    chk("halted_state", {29'd0, state}, 32'd7);
    chk("halted_flag", {31'd0, halted}, 32'd1);
    chk("halted_pipe_en", {31'd0, pipe_en}, 32'd0);
    chk("halted_bubble", {31'd0, bubble}, 32'd0);
    chk("halted_count", cyc, exp_count);
  endtask

  initial begin
    tbl[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h4433_2211};
    tbl[1] = '{8'h55, 8'h66, 8'h77, 8'h88, 32'h8877_6655};
    tbl[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 32'hFF00_FF00};
    tbl[3] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBE_ADDE};
    tbl[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF};
    tbl[5] = '{8'h01, 8'h00, 8'h00, 8'h80, 32'h8000_0001};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
    chk("rst_pipe_en", {31'd0, pipe_en}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_count", cyc, 32'd0);
    rst_n = 1'b1;

    // Two-word load
    load_table(0, 2);

    // Run; HALT at fetch on the 5th run cycle
    send_byte(8'h52);
    repeat (4) @(posedge clk);
    #1 fetched = HALT_W;
    @(negedge clk);
    chk("run5_pc_en", {31'd0, pc_en}, 32'd1);
    chk("run5_state", {29'd0, state}, 32'd4);
    chk("run5_count", cyc, 32'd4);
    @(posedge clk);
    #1 fetched = NOP_W;
    drain_and_halt(32'd9);

    // HALTED consumes 'R' and 'S' without enabling the pipe
    send_byte(8'h52);
    @(negedge clk);
    chk("halt_r_state", {29'd0, state}, 32'd7);
    chk("halt_r_pc_en", {31'd0, pc_en}, 32'd0);
    send_byte(8'h53);
    @(negedge clk);
    chk("halt_s_state", {29'd0, state}, 32'd7);
    chk("halt_s_pipe_en", {31'd0, pipe_en}, 32'd0);
    chk("halt_s_halted", {31'd0, halted}, 32'd1);
    load_table(2, 1);

    // Unknown byte in IDLE is ignored
    send_byte(8'h00);
    @(negedge clk);
    chk("idle_junk_state", {29'd0, state}, 32'd0);

    // Three single steps
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h53);
      @(negedge clk);
      chk("step_pc_en", {31'd0, pc_en}, 32'd1);
      chk("step_pipe_en", {31'd0, pipe_en}, 32'd1);
      chk("step_ready", {31'd0, cmd_ready}, 32'd0);
      chk("step_state", {29'd0, state}, 32'd5);
      @(negedge clk);
      chk("step_idle_state", {29'd0, state}, 32'd0);
      chk("step_idle_pc_en", {31'd0, pc_en}, 32'd0);
    end
    chk("step_count", cyc, 32'd3);

    // Run, then pause on the same cycle HALT is fetched: HALT wins
    send_byte(8'h52);
    @(negedge clk);
    fetched   = HALT_W;
    cmd_valid = 1'b1;
    cmd_data  = 8'h50;
    chk("rp_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    fetched   = NOP_W;
    drain_and_halt(32'd8);

    // Reset in the middle of a word: no write, outputs back to reset values
    send_byte(8'h4C);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", {29'd0, state}, 32'd0);
    chk("mid_rst_halted", {31'd0, halted}, 32'd0);
    chk("mid_rst_count", cyc, 32'd0);
    chk("mid_rst_addr", {24'd0, wr_addr}, 32'd0);
    chk("mid_rst_data", wr_data, 32'd0);
    chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full table load after reset
    load_table(0, 6);

    // Count byte 0 loads 256 words, addresses 0..255
    send_byte(8'h4C);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      sb.push_back({8'(i), {8'hC3, ~8'(i), 8'h5A, 8'(i)}});
      send_byte(8'(i));
      send_byte(8'h5A);
      send_byte(~8'(i));
      send_byte(8'hC3);
    end
    expect_flush();

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
